// File: rtl/xbar_n.sv
// 1-to-N AXI-lite crossbar: one upstream master fanned out to N_SLV address-decoded slaves.
// Latency: +1 cycle upstream AR/AW valid to downstream valid; R/B/W data pass through with 0 added cycles.
// Backpressure: one outstanding read and one outstanding write; upstream ready is a pass-through of the selected slave's ready.
//
// Ports:
//   clk, rst             - single clock, synchronous active-high reset
//   s_ar*/s_r*           - upstream read address / read data channels
//   s_aw*/s_w*/s_b*      - upstream write address / write data / write response channels
//   m_*                  - N_SLV packed downstream ports, port i in slice i (mirrored directions)
//
// Build option: define XBAR_DECERR_EN to answer unmapped addresses locally with DECERR
// (resp 2'b11). Without it, unmapped addresses are routed to port N_SLV-1.
module xbar_n #(
    parameter int                      N_SLV    = 2,
    parameter int                      ADDR_W   = 32,
    parameter int                      DATA_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'ha0000048, 32'h0},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {32'hfffffff8, 32'h0}
) (
    input  logic                      clk,
    input  logic                      rst,
    // upstream read
    input  logic [ADDR_W-1:0]         s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    // upstream write
    input  logic [ADDR_W-1:0]         s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_W-1:0]         s_wdata,
    input  logic [DATA_W/8-1:0]       s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    // downstream read
    output logic [N_SLV*ADDR_W-1:0]   m_araddr,
    output logic [N_SLV-1:0]          m_arvalid,
    input  logic [N_SLV-1:0]          m_arready,
    input  logic [N_SLV*DATA_W-1:0]   m_rdata,
    input  logic [N_SLV*2-1:0]        m_rresp,
    input  logic [N_SLV-1:0]          m_rvalid,
    output logic [N_SLV-1:0]          m_rready,
    // downstream write
    output logic [N_SLV*ADDR_W-1:0]   m_awaddr,
    output logic [N_SLV-1:0]          m_awvalid,
    input  logic [N_SLV-1:0]          m_awready,
    output logic [N_SLV*DATA_W-1:0]   m_wdata,
    output logic [N_SLV*DATA_W/8-1:0] m_wstrb,
    output logic [N_SLV-1:0]          m_wvalid,
    input  logic [N_SLV-1:0]          m_wready,
    input  logic [N_SLV*2-1:0]        m_bresp,
    input  logic [N_SLV-1:0]          m_bvalid,
    output logic [N_SLV-1:0]          m_bready
);

    localparam int SW    = DATA_W / 8;
    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
`ifdef XBAR_DECERR_EN
        , R_ERR
`endif
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FWD,
        W_RESP
`ifdef XBAR_DECERR_EN
        , W_ERR
`endif
    } wr_state_t;

    // Lowest-index hit wins; a miss falls back to the last port.
    function automatic logic [SEL_W-1:0] dec_sel(input logic [ADDR_W-1:0] a);
        logic [SEL_W-1:0] idx;
        idx = SEL_W'(N_SLV - 1);
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((a & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])
                idx = SEL_W'(i);
        end
        return idx;
    endfunction

`ifdef XBAR_DECERR_EN
    function automatic logic dec_hit(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if ((a & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])
                hit = 1'b1;
        end
        return hit;
    endfunction
`endif

    rd_state_t         rd_state;
    logic [SEL_W-1:0]  rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    wr_state_t         wr_state;
    logic [SEL_W-1:0]  wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic              aw_done;
    logic              w_done;
`ifdef XBAR_DECERR_EN
    // Error read: first R_ERR cycle completes the AR handshake, later cycles present the response.
    logic              rd_err_acc;
`endif

    logic              aw_fire;
    logic              w_fire;
    logic [N_SLV-1:0]  rd_oh;
    logic [N_SLV-1:0]  wr_oh;

    // ---------------------------------------------------------------- read FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_sel   <= '0;
            rd_addr  <= '0;
`ifdef XBAR_DECERR_EN
            rd_err_acc <= 1'b0;
`endif
        end else begin
            case (rd_state)
                R_IDLE: if (s_arvalid) begin
                    rd_addr <= s_araddr;
                    rd_sel  <= dec_sel(s_araddr);
`ifdef XBAR_DECERR_EN
                    rd_state <= dec_hit(s_araddr) ? R_ADDR : R_ERR;
`else
                    rd_state <= R_ADDR;
`endif
                end
                R_ADDR: if (m_arready[rd_sel]) rd_state <= R_DATA;
                R_DATA: if (s_rvalid && s_rready) rd_state <= R_IDLE;
`ifdef XBAR_DECERR_EN
                R_ERR: begin
                    if (!rd_err_acc) begin
                        rd_err_acc <= 1'b1;
                    end else if (s_rready) begin
                        rd_err_acc <= 1'b0;
                        rd_state   <= R_IDLE;
                    end
                end
`endif
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- write FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_sel   <= '0;
            wr_addr  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (s_awvalid) begin
                    wr_addr <= s_awaddr;
                    wr_sel  <= dec_sel(s_awaddr);
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
`ifdef XBAR_DECERR_EN
                    wr_state <= dec_hit(s_awaddr) ? W_FWD : W_ERR;
`else
                    wr_state <= W_FWD;
`endif
                end
                W_FWD: begin
                    aw_done <= aw_done | aw_fire;
                    w_done  <= w_done | w_fire;
                    if ((aw_done || aw_fire) && (w_done || w_fire))
                        wr_state <= W_RESP;
                end
                W_RESP: if (s_bvalid && s_bready) begin
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    wr_state <= W_IDLE;
                end
`ifdef XBAR_DECERR_EN
                W_ERR: begin
                    aw_done <= aw_done | aw_fire;
                    w_done  <= w_done | w_fire;
                    if (s_bvalid && s_bready) begin
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        wr_state <= W_IDLE;
                    end
                end
`endif
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- upstream side
    always_comb begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = 2'b00;
        case (rd_state)
            R_ADDR: s_arready = m_arready[rd_sel];
            R_DATA: begin
                s_rvalid = m_rvalid[rd_sel];
                s_rdata  = m_rdata[rd_sel*DATA_W +: DATA_W];
                s_rresp  = m_rresp[rd_sel*2 +: 2];
            end
`ifdef XBAR_DECERR_EN
            R_ERR: begin
                s_arready = !rd_err_acc;
                s_rvalid  = rd_err_acc;
                s_rresp   = 2'b11;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        aw_fire   = 1'b0;
        w_fire    = 1'b0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = 2'b00;
        case (wr_state)
            W_FWD: begin
                s_awready = !aw_done && m_awready[wr_sel];
                s_wready  = !w_done && m_wready[wr_sel];
                aw_fire   = s_awready;
                w_fire    = s_wready && s_wvalid;
            end
            W_RESP: begin
                s_bvalid = m_bvalid[wr_sel];
                s_bresp  = m_bresp[wr_sel*2 +: 2];
            end
`ifdef XBAR_DECERR_EN
            W_ERR: begin
                s_awready = !aw_done;
                s_wready  = !w_done;
                aw_fire   = s_awready && s_awvalid;
                w_fire    = s_wready && s_wvalid;
                s_bvalid  = aw_done && w_done;
                s_bresp   = 2'b11;
            end
`endif
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- downstream side
    // Only the latched port is ever driven; every other slice stays all-zero.
    always_comb begin
        rd_oh = '0;
        wr_oh = '0;
        if (rd_state == R_ADDR || rd_state == R_DATA) rd_oh[rd_sel] = 1'b1;
        if (wr_state == W_FWD || wr_state == W_RESP)  wr_oh[wr_sel] = 1'b1;
        for (int i = 0; i < N_SLV; i++) begin
            m_arvalid[i]               = rd_oh[i] && (rd_state == R_ADDR);
            m_araddr[i*ADDR_W +: ADDR_W] = m_arvalid[i] ? rd_addr : '0;
            m_rready[i]                = rd_oh[i] && (rd_state == R_DATA) && s_rready;

            m_awvalid[i]               = wr_oh[i] && (wr_state == W_FWD) && !aw_done;
            m_awaddr[i*ADDR_W +: ADDR_W] = m_awvalid[i] ? wr_addr : '0;
            m_wvalid[i]                = wr_oh[i] && (wr_state == W_FWD) && !w_done && s_wvalid;
            m_wdata[i*DATA_W +: DATA_W]  = m_wvalid[i] ? s_wdata : '0;
            m_wstrb[i*SW +: SW]          = m_wvalid[i] ? s_wstrb : '0;
            m_bready[i]                = wr_oh[i] && (wr_state == W_RESP) && s_bready;
        end
    end

endmodule
